// File: rtl/id_pkg.sv
// Shared decode-stage constants: RV32I opcodes, the canonical NOP and the
// decode-holding FSM state type.
package id_pkg;

   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcFence  = 7'b0001111;
   localparam logic [6:0] OpcSystem = 7'b1110011;

   localparam logic [31:0] Nop = 32'h0000_0013;

   typedef enum logic [1:0] {
      StEmpty,
      StHold,
      StBubble
   } state_e;

   // FENCE and SYSTEM are deliberately outside the supported set.
   function automatic logic opc_legal(input logic [6:0] opc);
      logic r;
      case (opc)
         OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcBranch,
         OpcLoad, OpcStore, OpcOpImm, OpcOp: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/id_hazard.sv
// Load-use hazard detector: flags a held instruction whose used source
// register is the destination of a LOAD currently in EX.
module id_hazard
   import id_pkg::*;
(
   input  logic [31:0] i_instr,
   input  logic        i_load_valid,
   input  logic [4:0]  i_load_rd,
   output logic        o_hazard
);

   logic [6:0] w_opc;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic       w_use_rs1;
   logic       w_use_rs2;
   logic       w_unused_instr;

   assign w_opc = i_instr[6:0];
   assign w_rs1 = i_instr[19:15];
   assign w_rs2 = i_instr[24:20];

   assign w_use_rs1 = !(w_opc inside {OpcLui, OpcAuipc, OpcJal});
   assign w_use_rs2 = w_opc inside {OpcOp, OpcStore, OpcBranch};

   // x0 never carries a dependency.
   assign o_hazard = i_load_valid && (i_load_rd != 5'd0) &&
                     ((w_use_rs1 && (i_load_rd == w_rs1)) ||
                      (w_use_rs2 && (i_load_rd == w_rs2)));

   assign w_unused_instr = ^{i_instr[31:25], i_instr[14:7]};

endmodule

// File: rtl/id_ctrl.sv
// Decode-stage holding register: one-deep instruction buffer between fetch
// and EX with load-use bubble insertion, flush and illegal-opcode flagging.
module id_ctrl
   import id_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_if_valid,
   output logic        o_if_ready,
   input  logic [31:0] i_if_instr,
   input  logic [31:0] i_if_pc,
   output logic [31:0] o_dec_instr,
   output logic [31:0] o_dec_pc,
   output logic        o_ex_valid,
   input  logic        i_ex_ready,
   input  logic        i_ex_load_valid,
   input  logic [4:0]  i_ex_load_rd,
   input  logic        i_flush,
   output logic        o_illegal,
   output logic [15:0] o_stall_cnt
);

   state_e      r_state;
   state_e      w_state_next;
   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic [15:0] r_stall_cnt;
   logic        w_hazard;
   logic        w_issue;
   logic        w_fetch;

   id_hazard u_hazard (
      .i_instr      (r_instr),
      .i_load_valid (i_ex_load_valid),
      .i_load_rd    (i_ex_load_rd),
      .o_hazard     (w_hazard)
   );

   assign o_ex_valid = (r_state == StHold) && !w_hazard && !i_flush;
   assign w_issue    = o_ex_valid && i_ex_ready;
   // Gated by reset so fetch never sees ready while the stage is held in reset.
   assign o_if_ready = i_rst_n && !i_flush && ((r_state == StEmpty) || w_issue);
   assign w_fetch    = i_if_valid && o_if_ready;

   always_comb begin
      w_state_next = r_state;
      if (i_flush) begin
         w_state_next = StEmpty;
      end else begin
         unique case (r_state)
            StEmpty: begin
               if (i_if_valid) w_state_next = StHold;
            end
            StHold: begin
               if (w_hazard)                  w_state_next = StBubble;
               else if (w_issue && !i_if_valid) w_state_next = StEmpty;
            end
            StBubble: w_state_next = StHold;
            default:  w_state_next = StEmpty;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StEmpty;
         r_instr     <= Nop;
         r_pc        <= 32'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state <= w_state_next;
         if (w_fetch) begin
            r_instr <= i_if_instr;
            r_pc    <= i_if_pc;
         end else if (w_state_next == StEmpty) begin
            r_instr <= Nop;
         end
         if ((r_state == StBubble) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign o_dec_instr = r_instr;
   assign o_dec_pc    = r_pc;
   assign o_illegal   = (r_state != StEmpty) && !opc_legal(r_instr[6:0]);
   assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ctrl.sv
// Bench for id_ctrl: directed scenarios plus random traffic, checked against
// a behavioural model with an issue scoreboard drained by a separate monitor.
module tb_id_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
   logic        ex_valid;
   logic        ex_ready;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic        flush;
   logic        illegal;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   id_ctrl dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_if_valid      (if_valid),
      .o_if_ready      (if_ready),
      .i_if_instr      (if_instr),
      .i_if_pc         (if_pc),
      .o_dec_instr     (dec_instr),
      .o_dec_pc        (dec_pc),
      .o_ex_valid      (ex_valid),
      .i_ex_ready      (ex_ready),
      .i_ex_load_valid (ld_valid),
      .i_ex_load_rd    (ld_rd),
      .i_flush         (flush),
      .o_illegal       (illegal),
      .o_stall_cnt     (stall_cnt)
   );

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } issue_t;

   issue_t sb_q[$];
   int     n_checks = 0;
   int     n_errors = 0;

   // Behavioural model: an optional held instruction plus a pending-bubble flag.
   bit          m_valid;
   bit          m_bubble;
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   int unsigned m_stall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit uses_rs1(input logic [6:0] op);
      return !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
   endfunction

   function automatic bit uses_rs2(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0100011, 7'b1100011};
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                        7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
   endfunction

   task automatic model_reset();
      m_valid  = 0;
      m_bubble = 0;
      m_instr  = NOP;
      m_pc     = 32'd0;
      m_stall  = 0;
   endtask

   task automatic step(input bit fl, input bit iv, input logic [31:0] ins,
                       input logic [31:0] pc, input bit er, input bit lv,
                       input logic [4:0] lrd);
      bit hz, e_exv, e_rdy;
      @(posedge clk);
      #2;
      flush = fl; if_valid = iv; if_instr = ins; if_pc = pc;
      ex_ready = er; ld_valid = lv; ld_rd = lrd;
      #1;
      hz = m_valid && !m_bubble && lv && (lrd != 5'd0) &&
           ((uses_rs1(m_instr[6:0]) && lrd == m_instr[19:15]) ||
            (uses_rs2(m_instr[6:0]) && lrd == m_instr[24:20]));
      e_exv = m_valid && !m_bubble && !hz && !fl;
      e_rdy = !fl && (!m_valid || (e_exv && er));
      chk("if_ready", if_ready, e_rdy);
      chk("ex_valid", ex_valid, e_exv);
      chk("illegal", illegal, m_valid && !is_legal(m_instr[6:0]));
      chk("dec_instr", dec_instr, m_valid ? m_instr : NOP);
      if (m_valid) chk("dec_pc", dec_pc, m_pc);
      chk("stall_cnt", stall_cnt, m_stall);
      if (e_exv && er) sb_q.push_back('{instr: m_instr, pc: m_pc});
      if (m_bubble && m_stall < 32'hFFFF) m_stall++;
      if (fl) begin
         m_valid = 0; m_bubble = 0;
      end else if (e_rdy && iv) begin
         m_valid = 1; m_bubble = 0; m_instr = ins; m_pc = pc;
      end else if (m_bubble) begin
         m_bubble = 0;
      end else if (hz) begin
         m_bubble = 1;
      end else if (e_exv && er) begin
         m_valid = 0;
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [12];
      logic [31:0] r;
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
              7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011, 7'b0000000};
      r = $urandom();
      return {r[31:25], 3'(r[2:0]) == 3'd0 ? 5'd0 : {3'b0, r[4:3]},
              {3'b0, r[6:5]}, r[14:12], r[11:7], ops[$urandom_range(0, 11)]};
   endfunction

   always @(negedge clk) begin
      if (rst_n && ex_valid && ex_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected_issue: got instr %h pc %h, expected no issue",
                     dec_instr, dec_pc);
         end else begin
            issue_t e;
            e = sb_q.pop_front();
            chk("issue_instr", dec_instr, e.instr);
            chk("issue_pc", dec_pc, e.pc);
         end
      end
   end

   localparam logic [31:0] ADD_X3_X1_X2 = 32'h0020_81B3;
   localparam logic [31:0] LUI_RS1_X5   = 32'h0002_82B7;

   initial begin
      rst_n = 0; if_valid = 0; if_instr = 0; if_pc = 0; ex_ready = 0;
      ld_valid = 0; ld_rd = 0; flush = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex_valid", ex_valid, 1'b0);
      chk("rst_if_ready", if_ready, 1'b0);
      chk("rst_illegal", illegal, 1'b0);
      chk("rst_dec_instr", dec_instr, NOP);
      chk("rst_dec_pc", dec_pc, 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      @(posedge clk); #2 rst_n = 1;

      // ADDI issue with pc 0x100
      step(0, 1, 32'h0050_0093, 32'h100, 1, 0, 0);
      step(0, 0, 32'h0, 32'h0, 1, 0, 0);
      // load-use on rs2, then rd=0 no bubble
      step(0, 1, ADD_X3_X1_X2, 32'h200, 1, 0, 0);
      step(0, 0, 32'h0, 32'h0, 1, 1, 5'd2);
      step(0, 0, 32'h0, 32'h0, 1, 1, 5'd2);
      step(0, 0, 32'h0, 32'h0, 1, 0, 5'd0);
      chk("stall_after_bubble", stall_cnt, 32'd1);
      step(0, 1, ADD_X3_X1_X2, 32'h204, 1, 0, 0);
      step(0, 0, 32'h0, 32'h0, 1, 1, 5'd0);
      // LUI ignores rs1 field
      step(0, 1, LUI_RS1_X5, 32'h208, 1, 0, 0);
      step(0, 0, 32'h0, 32'h0, 1, 1, 5'd5);
      // back-to-back fetches, then EX stall for 3 cycles
      for (int i = 0; i < 6; i++) step(0, 1, 32'h0000_0093 | (i << 20), 32'h400 + 4 * i, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 32'h0010_8113, 32'h500, 0, 0, 0);
      step(0, 0, 32'h0, 32'h0, 1, 0, 0);
      // flush coincident with fetch and issue
      step(0, 1, 32'h0050_0093, 32'h600, 0, 0, 0);
      step(1, 1, 32'h0030_0113, 32'h604, 1, 0, 0);
      step(0, 0, 32'h0, 32'h0, 1, 0, 0);
      // illegal opcodes held under EX stall
      step(0, 1, 32'h0000_0073, 32'h700, 0, 0, 0);
      step(0, 0, 32'h0, 32'h0, 0, 0, 0);
      step(1, 0, 32'h0, 32'h0, 0, 0, 0);
      step(0, 1, 32'h0000_0000, 32'h704, 0, 0, 0);
      step(0, 0, 32'h0, 32'h0, 0, 0, 0);
      step(1, 0, 32'h0, 32'h0, 0, 0, 0);

      // asynchronous reset while holding an instruction
      step(0, 1, ADD_X3_X1_X2, 32'h800, 0, 0, 0);
      @(posedge clk);
      #2;
      if_valid = 0; ex_ready = 1; rst_n = 0;
      #1;
      chk("midrst_ex_valid", ex_valid, 1'b0);
      chk("midrst_if_ready", if_ready, 1'b0);
      chk("midrst_dec_instr", dec_instr, NOP);
      chk("midrst_dec_pc", dec_pc, 32'd0);
      chk("midrst_stall_cnt", stall_cnt, 32'd0);
      model_reset();
      @(posedge clk); #2 rst_n = 1;

      for (int n = 0; n < 800; n++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
              $urandom(), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 3)));
      end
      step(0, 0, 32'h0, 32'h0, 1, 0, 0);
      @(posedge clk);
      #1;
      chk("sb_drain", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_ctrl.md
ID_CTRL -- requirements
Module: id_ctrl

Interface
REQ-001 SHALL have ports: i_clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: i_rst_n  input  1  asynchronous, active-low reset.
REQ-003 i_if_valid  input  1  fetch offers an instruction.
REQ-004 o_if_ready  output  1  decode stage accepts the offered instruction.
REQ-005 i_if_instr  input  32  fetched instruction word.
REQ-006 i_if_pc  input  32  PC of the fetched instruction.
REQ-007 o_dec_instr  output  32  held instruction, to the immediate generator and decoder.
REQ-008 o_dec_pc  output  32  PC of the held instruction.
REQ-009 o_ex_valid  output  1  held instruction is issued to EX this cycle.
REQ-010 i_ex_ready  input  1  EX accepts the issue.
REQ-011 i_ex_load_valid  input  1  the instruction in EX is a LOAD.
REQ-012 i_ex_load_rd  input  5  destination register of that LOAD.
REQ-013 i_flush  input  1  branch/jump redirect; kill the held instruction.
REQ-014 o_illegal  output  1  held instruction has an unsupported opcode.
REQ-015 o_stall_cnt  output  16  saturating count of load-use bubble cycles.

Function
REQ-016 SHALL hold at most one instruction; states EMPTY, HOLD, BUBBLE.
REQ-017 SHALL drive o_if_ready = (EMPTY) or (HOLD and o_ex_valid and i_ex_ready), with no flush asserted.
REQ-018 Fetch transfer: i_if_valid and o_if_ready; SHALL capture instr/pc and go to (or stay in) HOLD.
REQ-019 SHALL drive o_ex_valid = HOLD and not hazard and not i_flush; o_ex_valid is 0 in EMPTY and BUBBLE.
REQ-020 Hazard: i_ex_load_valid, i_ex_load_rd != 0, and rd equals a used source of the held instruction.
REQ-021 rs1 ([19:15]) is used for all opcodes except LUI 0110111, AUIPC 0010111 and JAL 1101111.
REQ-022 rs2 ([24:20]) is used only for OP 0110011, STORE 0100011 and BRANCH 1100011.
REQ-023 HOLD with hazard SHALL go to BUBBLE for exactly one cycle, then return to HOLD; the held instruction is unchanged.
REQ-024 BUBBLE SHALL NOT re-evaluate the hazard; the next HOLD cycle re-evaluates with the current inputs.
REQ-025 Issue without new fetch (HOLD, o_ex_valid, i_ex_ready, no i_if_valid) SHALL go to EMPTY.
REQ-026 Issue with new fetch in the same cycle SHALL replace the held instruction and stay in HOLD (zero-bubble throughput).
REQ-027 HOLD with i_ex_ready=0 SHALL keep instr/pc stable and keep o_ex_valid asserted.
REQ-028 i_flush SHALL have top priority: next state EMPTY, any same-cycle fetch is discarded, and o_if_ready=0 that cycle.
REQ-029 o_dec_instr/o_dec_pc SHALL be registered values, stable across stall and BUBBLE cycles.
REQ-030 o_dec_instr SHALL be 32'h0000_0013 (NOP) whenever the state is EMPTY.
REQ-031 o_illegal SHALL be 1 in HOLD/BUBBLE when [1:0] != 2'b11 or the opcode is not one of the 9 RV32I base opcodes.
REQ-032 o_illegal SHALL be 1 in HOLD/BUBBLE when the opcode is 0001111/1110011, and 0 in EMPTY.
REQ-033 o_stall_cnt SHALL increment once per BUBBLE cycle and saturate at 16'hFFFF; it is cleared only by reset.

Reset
REQ-034 While i_rst_n=0, state SHALL be EMPTY and o_ex_valid=0, o_if_ready=0, o_illegal=0.
REQ-035 While i_rst_n=0, o_dec_instr=32'h13, o_dec_pc=0 and o_stall_cnt=0.
REQ-036 o_if_ready SHALL assert in the first cycle after reset release.
REQ-037 Reset asserted mid-BUBBLE or mid-HOLD SHALL drop the instruction immediately (asynchronous); no issue occurs after reset.

Structure
REQ-038 Opcode localparams, the NOP constant and the state enum SHALL live in shared package id_pkg.
REQ-039 Hazard detection SHALL be a combinational sub-module id_hazard (instr, load_valid, load_rd -> hazard).

Verification
REQ-040 Reset release, then fetch of ADDI 0x00500093 @pc 0x100 with i_ex_ready=1 -> o_ex_valid the next cycle, o_dec_pc=0x100.
REQ-041 Hold ADD x3,x1,x2 with i_ex_load_valid=1, rd=2 -> one cycle o_ex_valid=0, o_stall_cnt=1, then issue; rd=0 -> no bubble.
REQ-042 Hold LUI with load rd = instr[19:15] -> no bubble (rs1 unused).
REQ-043 Back-to-back fetches with i_ex_ready=1 -> one issue per cycle; i_ex_ready=0 for 3 cycles -> instr stable, o_if_ready=0.
REQ-044 Flush coincident with fetch and issue -> EMPTY, fetched word dropped, o_dec_instr=0x13.
REQ-045 Held 0x00000073 (SYSTEM) -> o_illegal=1; held 0x00000000 -> o_illegal=1.
